regfile_wb_arbiter: RTL and testbench

// - Shares the single register-file write port (we/rW/din) between NREQ write-back requesters
//   (ALU, load unit, CSR/ecall path).
// - Round-robin grant, one write per cycle, registered write stage toward the register file.
// - Exposes per-register in-flight bits for the hazard unit.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file write-back arbiter
// Contents: register address width, register count, write-back request struct,
// and a helper that turns a register address into a one-hot register mask.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DATA_W  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t              rd;
    logic [WB_DATA_W-1:0]   data;
  } wb_req_t;

  // One-hot mask with only bit r set.
  function automatic logic [NUM_REGS-1:0] reg_bit(input reg_addr_t r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  index with highest priority this cycle (must be < N)
//   grant out N   one-hot grant, zero when no request
//   idx   out PW  index of the granted requester (0 when none)
//   any   out 1   some requester was granted
// The pointer register lives in the parent; this block has no state.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk the N candidates starting at ptr, wrapping at N; first hit wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register-file write port
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/rd/data        NREQ write-back requesters (slice i per requester)
//   req_ready                one-hot grant, transfer when valid & ready
//   rf_we/rf_rw/rf_din       registered write stage toward the register file
//   inflight                 bit r: write to r granted, not yet committed
//   grant_cnt                wrapping count of accepted transfers (x0 included)
// Optional macro WB_BYPASS_EN adds byp_ra/byp_rb/byp_r1/byp_r2 inputs and
// byp_o1/byp_o2 outputs that forward the staged write to register-file readers.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_rw,
  output logic [WIDTH-1:0]           rf_din,
  output logic [NUM_REGS-1:0]        inflight,
  output logic [15:0]                grant_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]      byp_ra,
  input  logic [REG_ADDR_W-1:0]      byp_rb,
  input  logic [WIDTH-1:0]           byp_r1,
  input  logic [WIDTH-1:0]           byp_r2,
  output logic [WIDTH-1:0]           byp_o1,
  output logic [WIDTH-1:0]           byp_o2
`endif
);

  localparam int             PW   = $clog2(NREQ);
  localparam logic [PW-1:0]  LAST = PW'(NREQ - 1);

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 rf_we_q, rf_we_d;
  reg_addr_t            rf_rw_q, rf_rw_d;
  logic [WIDTH-1:0]     rf_din_q, rf_din_d;
  logic [NUM_REGS-1:0]  inflight_q, inflight_d;
  logic [15:0]          grant_cnt_q, grant_cnt_d;

  logic [NREQ-1:0]      grant;
  logic [PW-1:0]        grant_idx;
  logic                 grant_any;
  logic                 accept;
  reg_addr_t            sel_rd;
  logic [WIDTH-1:0]     sel_data;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // No handshake may complete while reset is asserted, even with valids high.
  assign req_ready = grant & {NREQ{rst}};
  assign accept    = grant_any & rst;

  // Grant is one-hot, so OR-ing the gated slices selects the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_rw_d     = rf_rw_q;
    rf_din_d    = rf_din_q;
    grant_cnt_d = grant_cnt_q;
    inflight_d  = inflight_q;

    // Commit: the register file writes rf_rw at this edge.
    if (rf_we_q) begin
      inflight_d = inflight_d & ~reg_bit(rf_rw_q);
    end

    if (accept) begin
      rr_ptr_d    = (grant_idx == LAST) ? '0 : grant_idx + PW'(1);
      rf_we_d     = (sel_rd != '0);
      rf_rw_d     = sel_rd;
      rf_din_d    = sel_data;
      grant_cnt_d = grant_cnt_q + 16'd1;
      // Applied after the clear so a new write to the same register keeps its bit.
      if (sel_rd != '0) begin
        inflight_d = inflight_d | reg_bit(sel_rd);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_rw_q     <= '0;
      rf_din_q    <= '0;
      inflight_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_rw_q     <= rf_rw_d;
      rf_din_q    <= rf_din_d;
      inflight_q  <= inflight_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rw     = rf_rw_q;
  assign rf_din    = rf_din_q;
  assign inflight  = inflight_q;
  assign grant_cnt = grant_cnt_q;

`ifdef WB_BYPASS_EN
  // Readers sampling the register file in the commit cycle would see stale data;
  // forward the staged write instead. x0 is never forwarded.
  logic hit_a;
  logic hit_b;

  assign hit_a  = rf_we_q && (byp_ra == rf_rw_q) && (rf_rw_q != '0);
  assign hit_b  = rf_we_q && (byp_rb == rf_rw_q) && (rf_rw_q != '0);
  assign byp_o1 = hit_a ? rf_din_q : byp_r1;
  assign byp_o2 = hit_b ? rf_din_q : byp_r2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*5-1:0]   req_rd;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rf_we;
  logic [4:0]          rf_rw;
  logic [WIDTH-1:0]    rf_din;
  logic [31:0]         inflight;
  logic [15:0]         grant_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]          byp_ra;
  logic [4:0]          byp_rb;
  logic [WIDTH-1:0]    byp_r1;
  logic [WIDTH-1:0]    byp_r2;
  logic [WIDTH-1:0]    byp_o1;
  logic [WIDTH-1:0]    byp_o2;
`endif

  regfile_wb_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_rw     (rf_rw),
    .rf_din    (rf_din),
    .inflight  (inflight),
    .grant_cnt (grant_cnt)
`ifdef WB_BYPASS_EN
    ,
    .byp_ra    (byp_ra),
    .byp_rb    (byp_rb),
    .byp_r1    (byp_r1),
    .byp_r2    (byp_r2),
    .byp_o1    (byp_o1),
    .byp_o2    (byp_o2)
`endif
  );

  typedef struct {
    logic [4:0]       rw;
    logic [WIDTH-1:0] din;
  } wb_exp_t;

  int      grant_q[$];
  wb_exp_t wb_q[$];
  int      pass_cnt  = 0;
  int      total_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rw, input logic [WIDTH-1:0] din);
    wb_exp_t e;
    e.rw  = rw;
    e.din = din;
    wb_q.push_back(e);
  endtask

  // Monitor: pops expected grants on every handshake, expected writes on every rf_we.
  initial begin
    int      g;
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (req_ready != '0) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", 32'(req_ready), 32'd0);
          end else begin
            g = grant_q.pop_front();
            check("grant", 32'(req_ready), 32'(1) << g);
          end
        end
        if (rf_we === 1'b1) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected", 32'(rf_we), 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("wb_rw", 32'(rf_rw), 32'(e.rw));
            check("wb_din", rf_din, e.din);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
`ifdef WB_BYPASS_EN
    byp_ra = '0;
    byp_rb = '0;
    byp_r1 = '0;
    byp_r2 = '0;
`endif
    #2 rst = 1'b0;

    // Reset held with all requesters valid.
    @(posedge clk);
    #1;
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(posedge clk);
    @(posedge clk);
    #2;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_inflight", inflight, 32'd0);
    check("reset_cnt", 32'(grant_cnt), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;

    // Single request on requester 1.
    req_valid           = 3'b010;
    req_rd[5 +: 5]      = 5'd5;
    req_data[32 +: 32]  = 32'hDEAD_BEEF;
    grant_q.push_back(1);
    push_wb(5'd5, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("single_we", 32'(rf_we), 32'd1);
    check("single_inflight_set", inflight, 32'h0000_0020);
    @(posedge clk);
    #2;
    check("single_inflight_clr", inflight, 32'd0);
    check("single_we_drop", 32'(rf_we), 32'd0);
    check("single_cnt", 32'(grant_cnt), 32'd1);

    // Reset pulse to restart the pointer at 0.
    @(posedge clk);
    #1 rst = 1'b0;
    #3 rst = 1'b1;
    check("pulse_cnt", 32'(grant_cnt), 32'd0);

    // Fairness: all three valid for six grants.
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int r = 0; r < 2; r++) begin
      grant_q.push_back(0);
      grant_q.push_back(1);
      grant_q.push_back(2);
      push_wb(5'd1, 32'h1111_1111);
      push_wb(5'd2, 32'h2222_2222);
      push_wb(5'd3, 32'h3333_3333);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2;
      check("fair_we", 32'(rf_we), 32'd1);
    end
    req_valid = '0;
    check("fair_cnt", 32'(grant_cnt), 32'd6);

    // x0 write from requester 2: accepted and counted, nothing written.
    req_valid        = 3'b100;
    req_rd[10 +: 5]  = 5'd0;
    req_data[64 +: 32] = 32'h0BAD_F00D;
    grant_q.push_back(2);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("x0_cnt", 32'(grant_cnt), 32'd7);
    check("x0_we", 32'(rf_we), 32'd0);
    check("x0_inflight", inflight, 32'd0);

    // Back-to-back writes to x7: set beats clear on the overlapping edge.
    req_valid        = 3'b001;
    req_rd[0 +: 5]   = 5'd7;
    req_data[0 +: 32] = 32'hA1A1_A1A1;
    grant_q.push_back(0);
    push_wb(5'd7, 32'hA1A1_A1A1);
    @(posedge clk);
    #1;
    req_valid          = 3'b010;
    req_rd[5 +: 5]     = 5'd7;
    req_data[32 +: 32] = 32'hB2B2_B2B2;
    grant_q.push_back(1);
    push_wb(5'd7, 32'hB2B2_B2B2);
    #1;
    check("b2b_set", inflight, 32'h0000_0080);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("b2b_hold", inflight, 32'h0000_0080);
    @(posedge clk);
    #2;
    check("b2b_clear", inflight, 32'd0);
    check("b2b_cnt", 32'(grant_cnt), 32'd9);

    // Async reset between accept and commit; pointer is at 2, so requester 0 wins.
    req_valid         = 3'b001;
    req_rd[0 +: 5]    = 5'd9;
    req_data[0 +: 32] = 32'hC0FF_EE01;
    grant_q.push_back(0);
    @(posedge clk);
    #1;
    req_valid = '0;
`ifdef WB_BYPASS_EN
    byp_ra = 5'd9;
    byp_r1 = 32'h1111_0001;
    byp_rb = 5'd8;
    byp_r2 = 32'h2222_0002;
`endif
    #1;
    check("pre_reset_we", 32'(rf_we), 32'd1);
    check("pre_reset_rw", 32'(rf_rw), 32'd9);
`ifdef WB_BYPASS_EN
    check("byp_hit", byp_o1, 32'hC0FF_EE01);
    check("byp_miss", byp_o2, 32'h2222_0002);
`endif
    rst = 1'b0;
    #1;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_inflight", inflight, 32'd0);
    check("rst_cnt", 32'(grant_cnt), 32'd0);
`ifdef WB_BYPASS_EN
    check("byp_after_rst", byp_o1, 32'h1111_0001);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Recovery after reset: pointer back at 0, requester 1 alone.
    req_valid          = 3'b010;
    req_rd[5 +: 5]     = 5'd12;
    req_data[32 +: 32] = 32'h1212_1212;
    grant_q.push_back(1);
    push_wb(5'd12, 32'h1212_1212);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("final_cnt", 32'(grant_cnt), 32'd1);
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("wb_q_empty", 32'(wb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
